// File: rtl/multdiv_sequencer.sv
// Sequences one mul/div from DX through the multi-cycle unit: detect, start pulse, wait, inject into XM.
// Latency: detect + start + N unit cycles + 1 inject cycle; stall is held from detect until the result returns.
module multdiv_sequencer #(
  parameter int          TIMEOUT    = 40,
  parameter logic [31:0] MULT_EXC   = 32'd1,
  parameter logic [31:0] DIV_EXC    = 32'd2,
  parameter logic [4:0]  STATUS_REG = 5'd30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_ir,
  input  logic        dx_valid,
  input  logic [31:0] dx_opA,
  input  logic [31:0] dx_opB,
  input  logic        flush,
  input  logic        md_resultRDY,
  input  logic        md_exception,
  input  logic [31:0] md_result,
  output logic        md_ctrl_mult,
  output logic        md_ctrl_div,
  output logic [31:0] md_opA,
  output logic [31:0] md_opB,
  output logic        stall,
  output logic        xm_inject,
  output logic [31:0] xm_result,
  output logic [4:0]  xm_rd,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  counter;
  logic [31:0]    op_a, op_b, res_q;
  logic [4:0]     rd_q;
  logic           div_q, exc_q;
  logic           is_md, ir_div, timed_out, accept;
  logic           unused_ir;

  assign ir_div    = (dx_ir[6:2] == 5'b00111);
  assign is_md     = dx_valid && (dx_ir[31:27] == 5'b00000) &&
                     ((dx_ir[6:2] == 5'b00110) || ir_div);
  assign accept    = (state == IDLE) && is_md && !flush;
  assign timed_out = (counter == CW'(TIMEOUT - 1));
  assign unused_ir = ^{dx_ir[21:7], dx_ir[1:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (is_md && !flush) state_nxt = START;
      START: state_nxt = flush ? IDLE : BUSY;
      BUSY: begin
        if (flush)                          state_nxt = IDLE;
        else if (md_resultRDY || timed_out) state_nxt = DONE;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands, destination and outcome are held from detect until the next IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_a    <= '0;
      op_b    <= '0;
      rd_q    <= '0;
      div_q   <= 1'b0;
      res_q   <= '0;
      exc_q   <= 1'b0;
      counter <= '0;
    end else begin
      if (accept) begin
        op_a  <= dx_opA;
        op_b  <= dx_opB;
        rd_q  <= dx_ir[26:22];
        div_q <= ir_div;
        exc_q <= 1'b0;
      end
      if (state == BUSY && !flush) begin
        if (md_resultRDY) begin
          res_q <= md_result;
          exc_q <= md_exception;
        end else if (timed_out) begin
          exc_q <= 1'b1;
        end
      end
      if (state == BUSY && state_nxt == BUSY) counter <= counter + 1'b1;
      else                                    counter <= '0;
    end
  end

  assign md_opA = op_a;
  assign md_opB = op_b;

  always_comb begin
    md_ctrl_mult = 1'b0;
    md_ctrl_div  = 1'b0;
    stall        = 1'b0;
    xm_inject    = 1'b0;
    xm_result    = '0;
    xm_rd        = '0;
    busy         = (state != IDLE);
    case (state)
      // Reset gating keeps stall low while reset is asserted with a mul/div sitting in DX.
      IDLE:  stall = is_md && !flush && reset;
      START: begin
        stall        = 1'b1;
        md_ctrl_mult = !div_q;
        md_ctrl_div  = div_q;
      end
      BUSY:  stall = 1'b1;
      DONE: begin
        xm_inject = 1'b1;
        if (exc_q) begin
          xm_rd     = STATUS_REG;
          xm_result = div_q ? DIV_EXC : MULT_EXC;
        end else begin
          xm_rd     = rd_q;
          xm_result = res_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Bench for multdiv_sequencer: scripted mul/div sequences with an inject scoreboard.
module tb_multdiv_sequencer;

  localparam int TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] dx_ir = '0;
  logic        dx_valid = 1'b0;
  logic [31:0] dx_opA = '0, dx_opB = '0;
  logic        flush = 1'b0;
  logic        md_resultRDY = 1'b0;
  logic        md_exception = 1'b0;
  logic [31:0] md_result = '0;
  logic        md_ctrl_mult, md_ctrl_div, stall, xm_inject, busy;
  logic [31:0] md_opA, md_opB, xm_result;
  logic [4:0]  xm_rd;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  multdiv_sequencer #(.TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .dx_ir(dx_ir), .dx_valid(dx_valid),
    .dx_opA(dx_opA), .dx_opB(dx_opB), .flush(flush),
    .md_resultRDY(md_resultRDY), .md_exception(md_exception), .md_result(md_result),
    .md_ctrl_mult(md_ctrl_mult), .md_ctrl_div(md_ctrl_div),
    .md_opA(md_opA), .md_opB(md_opB), .stall(stall), .xm_inject(xm_inject),
    .xm_result(xm_result), .xm_rd(xm_rd), .busy(busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired, simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] mk_ir(input logic dv, input logic [4:0] rd);
    return {5'b00000, rd, 15'd0, (dv ? 5'b00111 : 5'b00110), 2'b00};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic bubble();
    dx_valid = 1'b0;
    dx_ir    = '0;
  endtask

  // Scoreboard: every inject must match the oldest expected write.
  always @(negedge clock) begin
    if (reset) begin
      if (xm_inject) begin
        exp_t e;
        n_cmp++;
        if (q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_inject rd=%0d result=%0d required no inject", xm_rd, xm_result);
        end else begin
          e = q.pop_front();
          if (xm_rd !== e.rd || xm_result !== e.val) begin
            n_err++;
            $display("FAIL inject_value rd=%0d result=%0d required rd=%0d result=%0d",
                     xm_rd, xm_result, e.rd, e.val);
          end
        end
      end
      if (xm_inject && stall) begin
        n_err++;
        $display("FAIL inject_stall_overlap inject=1 stall=1 required not both");
      end
      if (md_ctrl_mult && md_ctrl_div) begin
        n_err++;
        $display("FAIL start_overlap mult=1 div=1 required at most one");
      end
    end
  end

  // Runs one full sequence; the unit answers n cycles after the start pulse. Ends in the inject cycle.
  task automatic do_op(input logic dv, input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                       input int n, input logic [31:0] res, input logic exc);
    exp_t e;
    e.rd  = exc ? 5'd30 : rd;
    e.val = exc ? (dv ? 32'd2 : 32'd1) : res;
    q.push_back(e);
    dx_valid = 1'b1; dx_ir = mk_ir(dv, rd); dx_opA = a; dx_opB = b;
    @(negedge clock);
    n_cmp++;
    if (stall !== 1'b1 || busy !== 1'b0 || md_ctrl_mult !== 1'b0 || md_ctrl_div !== 1'b0) begin
      n_err++;
      $display("FAIL detect stall=%b busy=%b mult=%b div=%b required 1 0 0 0", stall, busy, md_ctrl_mult, md_ctrl_div);
    end
    cyc();
    dx_opA = 32'hFFFF_FFFF; dx_opB = 32'hFFFF_FFFF;
    @(negedge clock);
    n_cmp++;
    if (md_ctrl_mult !== !dv || md_ctrl_div !== dv || stall !== 1'b1 || md_opA !== a || md_opB !== b) begin
      n_err++;
      $display("FAIL start mult=%b div=%b stall=%b opA=%0d opB=%0d required %b %b 1 %0d %0d",
               md_ctrl_mult, md_ctrl_div, stall, md_opA, md_opB, !dv, dv, a, b);
    end
    for (int i = 2; i <= n; i++) begin
      cyc();
      @(negedge clock);
      n_cmp++;
      if (stall !== 1'b1 || md_ctrl_mult !== 1'b0 || md_ctrl_div !== 1'b0 || xm_inject !== 1'b0) begin
        n_err++;
        $display("FAIL busy_wait cyc=%0d stall=%b mult=%b div=%b inject=%b required 1 0 0 0",
                 i, stall, md_ctrl_mult, md_ctrl_div, xm_inject);
      end
    end
    cyc();
    md_resultRDY = 1'b1; md_result = res; md_exception = exc;
    @(negedge clock);
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL result_cycle_stall stall=%b required 1", stall);
    end
    cyc();
    md_resultRDY = 1'b0; md_result = '0; md_exception = 1'b0;
    @(negedge clock);
    n_cmp++;
    if (xm_inject !== 1'b1 || stall !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL done inject=%b stall=%b busy=%b required 1 0 1", xm_inject, stall, busy);
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({md_ctrl_mult, md_ctrl_div, stall, xm_inject, busy} !== 5'b0 ||
        md_opA !== 0 || md_opB !== 0 || xm_result !== 0 || xm_rd !== 0) begin
      n_err++;
      $display("FAIL reset_outputs ctrl=%b%b stall=%b inject=%b busy=%b opA=%0d opB=%0d res=%0d rd=%0d required all 0",
               md_ctrl_mult, md_ctrl_div, stall, xm_inject, busy, md_opA, md_opB, xm_result, xm_rd);
    end
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_mul();
    do_op(1'b0, 5'd5, 32'd6, 32'd7, 5, 32'd42, 1'b0);
    cyc();
    bubble();
    @(negedge clock);
    n_cmp++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mul_return_idle stall=%b busy=%b required 0 0", stall, busy);
    end
    cyc();
  endtask

  task automatic test_div_exc();
    do_op(1'b1, 5'd9, 32'd7, 32'd0, 3, 32'hDEAD_BEEF, 1'b1);
    cyc();
    bubble();
    cyc();
  endtask

  task automatic test_timeout();
    exp_t e;
    int   cnt = 0;
    e.rd = 5'd30; e.val = 32'd1;
    q.push_back(e);
    dx_valid = 1'b1; dx_ir = mk_ir(1'b0, 5'd3); dx_opA = 32'd1; dx_opB = 32'd1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (!stall) break;
      cnt++;
      cyc();
    end
    n_cmp++;
    if (cnt !== TIMEOUT + 2 || xm_inject !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_stall_cycles cycles=%0d inject=%b required %0d 1", cnt, xm_inject, TIMEOUT + 2);
    end
    cyc();
    bubble();
    cyc();
  endtask

  task automatic test_flush();
    dx_valid = 1'b1; dx_ir = mk_ir(1'b0, 5'd4); dx_opA = 32'd2; dx_opB = 32'd3;
    cyc();
    @(negedge clock);
    n_cmp++;
    if (md_ctrl_mult !== 1'b1) begin
      n_err++;
      $display("FAIL flush_start mult=%b required 1", md_ctrl_mult);
    end
    cyc();
    cyc();
    cyc();
    flush = 1'b1; md_resultRDY = 1'b1; md_result = 32'd99;
    @(negedge clock);
    n_cmp++;
    if (stall !== 1'b1) begin
      n_err++;
      $display("FAIL flush_cycle_stall stall=%b required 1", stall);
    end
    cyc();
    flush = 1'b0; md_resultRDY = 1'b0; md_result = '0;
    bubble();
    @(negedge clock);
    n_cmp++;
    if (stall !== 1'b0 || busy !== 1'b0 || xm_inject !== 1'b0) begin
      n_err++;
      $display("FAIL after_flush stall=%b busy=%b inject=%b required 0 0 0", stall, busy, xm_inject);
    end
    cyc();
    md_resultRDY = 1'b1; md_result = 32'd77;
    cyc();
    md_resultRDY = 1'b0; md_result = '0;
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || xm_inject !== 1'b0 || stall !== 1'b0) begin
      n_err++;
      $display("FAIL stale_rdy busy=%b inject=%b stall=%b required 0 0 0", busy, xm_inject, stall);
    end
    cyc();
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 5'd1, 32'd3, 32'd4, 2, 32'd12, 1'b0);
    cyc();
    do_op(1'b1, 5'd0, 32'd20, 32'd5, 4, 32'd4, 1'b0);
    cyc();
    bubble();
    cyc();
  endtask

  task automatic test_reset_mid_busy();
    dx_valid = 1'b1; dx_ir = mk_ir(1'b1, 5'd7); dx_opA = 32'd11; dx_opB = 32'd13;
    cyc();
    cyc();
    cyc();
    @(negedge clock);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({md_ctrl_mult, md_ctrl_div, stall, xm_inject, busy} !== 5'b0 ||
        md_opA !== 0 || md_opB !== 0 || xm_result !== 0 || xm_rd !== 0) begin
      n_err++;
      $display("FAIL async_reset ctrl=%b%b stall=%b inject=%b busy=%b opA=%0d opB=%0d required all 0",
               md_ctrl_mult, md_ctrl_div, stall, xm_inject, busy, md_opA, md_opB);
    end
    cyc();
    bubble();
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (stall !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle stall=%b busy=%b required 0 0", stall, busy);
    end
    cyc();
    @(negedge clock);
    n_cmp++;
    if (busy !== 1'b0 || xm_inject !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_quiet busy=%b inject=%b required 0 0", busy, xm_inject);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div_exc();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_reset_mid_busy();
    n_cmp++;
    if (q.size() !== 0) begin
      n_err++;
      $display("FAIL missing_injects pending=%0d required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
